// File: rtl/queue_sensor_decoder.sv
// Beam-break sensor front end: synchronises and debounces the outer (A) and inner (B)
// sensors, then decodes crossing order into entry/exit pulses for the occupancy counter.
module queue_sensor_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic       full,
  input  logic       empty,
  output logic       up,
  output logic       down,
  output logic       reject,
  output logic       err,
  output logic       busy,
  output logic [2:0] dir_state
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6,
    ERR   = 3'd7
  } state_t;

  // Bit 1 carries sensor A and bit 0 sensor B, so r_filt reads directly as {fa,fb}.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [DBW-1:0] r_db_cnt [2];
  logic [TOW-1:0] r_to_cnt;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_active;
  logic   w_timeout;
  logic   w_entry_done;
  logic   w_exit_done;
  logic   w_up_nxt;
  logic   w_down_nxt;
  logic   w_reject_nxt;
  logic   w_err_nxt;
  logic   r_up;
  logic   r_down;
  logic   r_reject;
  logic   r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      for (int unsigned i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= {sens_a, sens_b};
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_filt[i]   <= ~r_filt[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_active  = (r_state != IDLE) && (r_state != ERR);
  assign w_timeout = w_active && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_to_cnt <= '0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_reject <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= (!w_active || (w_state_nxt != r_state)) ? '0 : r_to_cnt + TOW'(1);
      r_up     <= w_up_nxt;
      r_down   <= w_down_nxt;
      r_reject <= w_reject_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Each active state accepts its own pattern, the next one forward and the one back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: case (r_filt)
        2'b00:   w_state_nxt = IDLE;
        2'b10:   w_state_nxt = EN_A;
        2'b01:   w_state_nxt = EX_B;
        default: w_state_nxt = ERR;
      endcase
      EN_A: case (r_filt)
        2'b10:   w_state_nxt = EN_A;
        2'b11:   w_state_nxt = EN_AB;
        2'b00:   w_state_nxt = IDLE;
        default: w_state_nxt = ERR;
      endcase
      EN_AB: case (r_filt)
        2'b11:   w_state_nxt = EN_AB;
        2'b01:   w_state_nxt = EN_B;
        2'b10:   w_state_nxt = EN_A;
        default: w_state_nxt = ERR;
      endcase
      EN_B: case (r_filt)
        2'b01:   w_state_nxt = EN_B;
        2'b00:   w_state_nxt = IDLE;
        2'b11:   w_state_nxt = EN_AB;
        default: w_state_nxt = ERR;
      endcase
      EX_B: case (r_filt)
        2'b01:   w_state_nxt = EX_B;
        2'b11:   w_state_nxt = EX_AB;
        2'b00:   w_state_nxt = IDLE;
        default: w_state_nxt = ERR;
      endcase
      EX_AB: case (r_filt)
        2'b11:   w_state_nxt = EX_AB;
        2'b10:   w_state_nxt = EX_A;
        2'b01:   w_state_nxt = EX_B;
        default: w_state_nxt = ERR;
      endcase
      EX_A: case (r_filt)
        2'b10:   w_state_nxt = EX_A;
        2'b00:   w_state_nxt = IDLE;
        2'b11:   w_state_nxt = EX_AB;
        default: w_state_nxt = ERR;
      endcase
      ERR:     w_state_nxt = (r_filt == 2'b00) ? IDLE : ERR;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = ERR;
  end

  always_comb begin
    w_entry_done = (r_state == EN_B) && (w_state_nxt == IDLE);
    w_exit_done  = (r_state == EX_A) && (w_state_nxt == IDLE);
    w_up_nxt     = w_entry_done && !full;
    w_down_nxt   = w_exit_done && !empty;
    w_reject_nxt = (w_entry_done && full) || (w_exit_done && empty);
    w_err_nxt    = (w_state_nxt == ERR) && (r_state != ERR);
  end

  assign up        = r_up;
  assign down      = r_down;
  assign reject    = r_reject;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);
  assign dir_state = r_state;

endmodule

// File: tb/tb_queue_sensor_decoder.sv
// Directed bench for queue_sensor_decoder: a crossing-sequence model is compared every
// cycle, and literal expectations pin state traces, pulse counts and latencies.
module tb_queue_sensor_decoder;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int D_IDLE = 0;
  localparam int D_ENT  = 1;
  localparam int D_EXT  = 2;
  localparam int D_ERR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic full = 1'b0;
  logic empty = 1'b0;
  logic up, down, reject, err, busy;
  logic [2:0] dir_state;

  queue_sensor_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sens_a   (sens_a),
    .sens_b   (sens_b),
    .full     (full),
    .empty    (empty),
    .up       (up),
    .down     (down),
    .reject   (reject),
    .err      (err),
    .busy     (busy),
    .dir_state(dir_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: sync pipeline, sample history, direction + step along the crossing path.
  logic m_s1a = 0, m_s2a = 0, m_s1b = 0, m_s2b = 0, m_fa = 0, m_fb = 0;
  logic ha [DEB];
  logic hb [DEB];
  int   m_dir = D_IDLE;
  int   m_k = 0;
  int   m_cyc = 0;
  int   m_since = 0;
  logic e_up = 0, e_down = 0, e_rej = 0, e_err = 0;

  function automatic logic [1:0] pat(input int d, input int k);
    logic [1:0] p;
    p = 2'b00;
    if (d == D_ENT) begin
      case (k)
        1: p = 2'b10;
        2: p = 2'b11;
        3: p = 2'b01;
        default: p = 2'b00;
      endcase
    end else begin
      case (k)
        1: p = 2'b01;
        2: p = 2'b11;
        3: p = 2'b10;
        default: p = 2'b00;
      endcase
    end
    return p;
  endfunction

  function automatic logic [2:0] code(input int d, input int k);
    case (d)
      D_IDLE:  return 3'd0;
      D_ENT:   return 3'(k);
      D_EXT:   return 3'(3 + k);
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_reset();
    m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0; m_fa = 0; m_fb = 0;
    for (int i = 0; i < DEB; i++) begin ha[i] = 0; hb[i] = 0; end
    m_dir = D_IDLE; m_k = 0; m_since = m_cyc;
    e_up = 0; e_down = 0; e_rej = 0; e_err = 0;
  endtask

  task automatic model_step();
    logic [1:0] in;
    int pd, pk;
    logic adiff, bdiff;
    in = {m_fa, m_fb};
    m_cyc++;
    e_up = 0; e_down = 0; e_rej = 0;
    pd = m_dir; pk = m_k;
    if (m_dir == D_ERR) begin
      if (in == 2'b00) m_dir = D_IDLE;
    end else if (m_dir == D_IDLE) begin
      if (in == 2'b10) begin m_dir = D_ENT; m_k = 1; end
      else if (in == 2'b01) begin m_dir = D_EXT; m_k = 1; end
      else if (in != 2'b00) m_dir = D_ERR;
    end else if (m_cyc - m_since >= TMO) begin
      m_dir = D_ERR;
    end else if (in == pat(m_dir, m_k + 1)) begin
      if (m_k == 3) begin
        m_dir = D_IDLE;
        if (pd == D_ENT) begin
          if (full) e_rej = 1; else e_up = 1;
        end else begin
          if (empty) e_rej = 1; else e_down = 1;
        end
      end else m_k++;
    end else if (in == pat(m_dir, m_k - 1)) begin
      if (m_k == 1) m_dir = D_IDLE; else m_k--;
    end else if (in != pat(m_dir, m_k)) begin
      m_dir = D_ERR;
    end
    if (m_dir == D_IDLE || m_dir == D_ERR) m_k = 0;
    if (code(m_dir, m_k) != code(pd, pk)) m_since = m_cyc;
    e_err = (m_dir == D_ERR) && (pd != D_ERR);
    for (int i = DEB - 1; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
    ha[0] = m_s2a; hb[0] = m_s2b;
    adiff = 1; bdiff = 1;
    for (int i = 0; i < DEB; i++) begin
      if (ha[i] == m_fa) adiff = 0;
      if (hb[i] == m_fb) bdiff = 0;
    end
    if (adiff) m_fa = ~m_fa;
    if (bdiff) m_fb = ~m_fb;
    m_s2a = m_s1a; m_s1a = sens_a;
    m_s2b = m_s1b; m_s1b = sens_b;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  int errs = 0;
  int checks = 0;
  int n_up = 0, n_dn = 0, n_rj = 0, n_er = 0;
  int t_up = 0, t_er = 0;
  int trv [256];
  int trc [256];
  int tr_n = 0;
  int last_dir = 0;
  int s_up, s_dn, s_rj, s_er, st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("up", 32'(up), 32'(e_up));
    chk("down", 32'(down), 32'(e_down));
    chk("reject", 32'(reject), 32'(e_rej));
    chk("err", 32'(err), 32'(e_err));
    chk("busy", 32'(busy), 32'(m_dir != D_IDLE));
    chk("dir_state", 32'(dir_state), 32'(code(m_dir, m_k)));
    if (up === 1'b1) begin n_up++; t_up = cyc; end
    if (down === 1'b1) n_dn++;
    if (reject === 1'b1) n_rj++;
    if (err === 1'b1) begin n_er++; t_er = cyc; end
    if (int'(dir_state) != last_dir && tr_n < 256) begin
      trv[tr_n] = int'(dir_state);
      trc[tr_n] = cyc;
      tr_n++;
      last_dir = int'(dir_state);
    end
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    {sens_a, sens_b} = p;
    repeat (n) tick();
  endtask

  task automatic snap();
    s_up = n_up; s_dn = n_dn; s_rj = n_rj; s_er = n_er; st = tr_n;
  endtask

  task automatic exp_pulses(input string nm, input int u, input int d, input int r, input int e);
    chk({nm, "_up"}, n_up - s_up, u);
    chk({nm, "_down"}, n_dn - s_dn, d);
    chk({nm, "_reject"}, n_rj - s_rj, r);
    chk({nm, "_err"}, n_er - s_er, e);
  endtask

  task automatic exp_trace(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    chk({nm, "_trace_len"}, tr_n - st, n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_trace%0d", nm, i), trv[st + i], ev[i]);
  endtask

  initial begin
    int t0;
    tick();
    chk("rst_dir", 32'(dir_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({up, down, reject, err}), 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Entry with room in the counter
    snap();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    t0 = cyc;
    hold(2'b00, 12);
    exp_trace("entry", 4, 1, 2, 3, 0);
    exp_pulses("entry", 1, 0, 0, 0);
    chk("entry_latency", t_up - t0, 3 + DEB);

    // Exit while counter empty
    empty = 1'b1;
    snap();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
    empty = 1'b0;
    exp_trace("exit_empty", 4, 4, 5, 6, 0);
    exp_pulses("exit_empty", 0, 0, 1, 0);

    // Exit with occupants, then entry while counter full
    snap();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
    exp_pulses("exit", 0, 1, 0, 0);
    full = 1'b1;
    snap();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 12);
    full = 1'b0;
    exp_pulses("entry_full", 0, 0, 1, 0);

    // Back-out from the middle of an entry
    snap();
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
    exp_trace("backout", 4, 1, 2, 1, 0);
    exp_pulses("backout", 0, 0, 0, 0);
    chk("backout_busy", 32'(busy), 0);

    // Short glitch is filtered; a longer pulse reaches EN_A and backs out
    snap();
    hold(2'b10, 2); hold(2'b00, 12);
    exp_trace("glitch2", 0, 0, 0, 0, 0);
    exp_pulses("glitch2", 0, 0, 0, 0);
    snap();
    hold(2'b10, 6); hold(2'b00, 12);
    exp_trace("glitch6", 2, 1, 0, 0, 0);
    exp_pulses("glitch6", 0, 0, 0, 0);

    // Both bits flip together
    snap();
    hold(2'b10, 10); hold(2'b01, 10); hold(2'b00, 12);
    exp_trace("illegal", 3, 1, 7, 0, 0);
    exp_pulses("illegal", 0, 0, 0, 1);

    // Stuck in EN_AB until the timeout fires
    snap();
    hold(2'b10, 10); hold(2'b11, 30); hold(2'b00, 12);
    exp_trace("timeout", 4, 1, 2, 7, 0);
    exp_pulses("timeout", 0, 0, 0, 1);
    chk("timeout_cycles", trc[st + 2] - trc[st + 1], TMO);
    chk("timeout_err_cycle", t_er, trc[st + 2]);

    // Reset in EN_AB with the beams still broken
    hold(2'b10, 10); hold(2'b11, 8);
    chk("pre_rst_dir", 32'(dir_state), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dir", 32'(dir_state), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pulses", 32'({up, down, reject, err}), 0);
    tick();
    rst = 1'b1;
    t0 = cyc;
    snap();
    hold(2'b11, 12); hold(2'b00, 12);
    exp_trace("rst_held", 2, 7, 0, 0, 0);
    exp_pulses("rst_held", 0, 0, 0, 1);
    chk("rst_held_err_latency", trc[st] - t0, 3 + DEB);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got t=%0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
